// File: rtl/serial_disp_sched.sv
// serial_disp_sched: shared serial display bus scheduler.
// Round-robin arbitration between the LED bank and the 7-segment bank,
// MSB-first serial shift of the captured word, then a latch strobe for the
// bank that was served. A chain-clear request takes priority over both.
module serial_disp_sched #(
    parameter int LED_BITS = 16,
    parameter int SEG_BITS = 64,  // must be >= LED_BITS
    parameter int CLK_DIV  = 2    // clk cycles per sclk half period, >= 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,      // asynchronous, active low
    input  logic                clr_req_i,
    input  logic                req_led_i,
    input  logic [LED_BITS-1:0] led_data_i,
    output logic                ack_led_o,
    output logic                done_led_o,
    input  logic                req_seg_i,
    input  logic [SEG_BITS-1:0] seg_data_i,
    output logic                ack_seg_o,
    output logic                done_seg_o,
    output logic                sclk_o,
    output logic                sdout_o,
    output logic                disp_clrn_o,
    output logic                led_pen_o,
    output logic                seg_pen_o,
    output logic                busy_o
);

    localparam int CNT_W = $clog2(SEG_BITS + 1);
    // Phase counter spans one full bit time (both sclk halves) or one
    // latch/clear window; 2*CLK_DIV >= 2 so the width is at least 1.
    localparam int PH_W  = $clog2(2 * CLK_DIV);

    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_FULL  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LED  = CNT_W'(LED_BITS);
    localparam logic [CNT_W-1:0] CNT_SEG  = CNT_W'(SEG_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH,
        S_CLEAR
    } state_e;

    typedef enum logic {
        SRC_LED = 1'b0,
        SRC_SEG = 1'b1
    } src_e;

    state_e              state_q;
    src_e                win_q;
    src_e                rr_last_q;
    logic [SEG_BITS-1:0] sr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PH_W-1:0]     ph_q;
    logic                sclk_q;
    logic                sdout_q;
    logic                disp_clrn_q;
    logic                led_pen_q;
    logic                seg_pen_q;
    logic                ack_led_q;
    logic                ack_seg_q;
    logic                done_led_q;
    logic                done_seg_q;

    src_e                win_d;
    logic                any_req_d;
    logic [SEG_BITS-1:0] load_word_d;
    logic [CNT_W-1:0]    load_cnt_d;
    logic [SEG_BITS-1:0] sr_shl_d;

    // Arbitration: a lone requester wins outright; on a tie the bank that
    // was not served last time wins.
    always_comb begin
        any_req_d = req_led_i | req_seg_i;
        win_d     = SRC_LED;
        if (req_led_i && !req_seg_i) begin
            win_d = SRC_LED;
        end else if (req_seg_i && !req_led_i) begin
            win_d = SRC_SEG;
        end else if (rr_last_q == SRC_LED) begin
            win_d = SRC_SEG;
        end else begin
            win_d = SRC_LED;
        end
    end

    // Word to load in GRANT: LED data sits in the top bits so both banks
    // shift out of the same MSB; the rest is zero-filled.
    always_comb begin
        load_word_d = SEG_BITS'(led_data_i) << (SEG_BITS - LED_BITS);
        load_cnt_d  = CNT_LED;
        if (win_q == SRC_SEG) begin
            load_word_d = seg_data_i;
            load_cnt_d  = CNT_SEG;
        end
        sr_shl_d = sr_q << 1;
    end

    // Main sequencer: state, counters, shift register and all pin outputs
    // are registered here so the board pins never glitch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            win_q       <= SRC_LED;
            rr_last_q   <= SRC_SEG;
            sr_q        <= '0;
            cnt_q       <= '0;
            ph_q        <= '0;
            sclk_q      <= 1'b0;
            sdout_q     <= 1'b0;
            disp_clrn_q <= 1'b0;
            led_pen_q   <= 1'b0;
            seg_pen_q   <= 1'b0;
            ack_led_q   <= 1'b0;
            ack_seg_q   <= 1'b0;
            done_led_q  <= 1'b0;
            done_seg_q  <= 1'b0;
        end else begin
            // Handshake pulses last exactly one cycle.
            ack_led_q  <= 1'b0;
            ack_seg_q  <= 1'b0;
            done_led_q <= 1'b0;
            done_seg_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    ph_q        <= '0;
                    sclk_q      <= 1'b0;
                    sdout_q     <= 1'b0;
                    disp_clrn_q <= 1'b1;
                    if (clr_req_i) begin
                        state_q     <= S_CLEAR;
                        disp_clrn_q <= 1'b0;
                    end else if (any_req_d) begin
                        state_q <= S_GRANT;
                        win_q   <= win_d;
                        if (win_d == SRC_LED) begin
                            ack_led_q <= 1'b1;
                        end else begin
                            ack_seg_q <= 1'b1;
                        end
                    end
                end

                // Data is captured at the end of the ack cycle; later input
                // changes cannot reach the shift register.
                S_GRANT: begin
                    sr_q      <= load_word_d;
                    cnt_q     <= load_cnt_d;
                    rr_last_q <= win_q;
                    sdout_q   <= load_word_d[SEG_BITS-1];
                    sclk_q    <= 1'b0;
                    ph_q      <= '0;
                    state_q   <= S_SHIFT_LO;
                end

                S_SHIFT_LO: begin
                    if (ph_q == PH_HALF) begin
                        ph_q    <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= S_SHIFT_HI;
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end

                // sdout only moves on the falling sclk edge, so it is stable
                // across the whole high phase.
                S_SHIFT_HI: begin
                    if (ph_q == PH_HALF) begin
                        ph_q   <= '0;
                        sclk_q <= 1'b0;
                        sr_q   <= sr_shl_d;
                        cnt_q  <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_q <= S_LATCH;
                            sdout_q <= 1'b0;
                            if (win_q == SRC_LED) begin
                                led_pen_q <= 1'b1;
                            end else begin
                                seg_pen_q <= 1'b1;
                            end
                        end else begin
                            state_q <= S_SHIFT_LO;
                            sdout_q <= sr_shl_d[SEG_BITS-1];
                        end
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end

                S_LATCH: begin
                    if (ph_q == PH_FULL) begin
                        ph_q      <= '0;
                        led_pen_q <= 1'b0;
                        seg_pen_q <= 1'b0;
                        state_q   <= S_IDLE;
                        if (win_q == SRC_LED) begin
                            done_led_q <= 1'b1;
                        end else begin
                            done_seg_q <= 1'b1;
                        end
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end

                // Chain clear: no handshake and arbitration history untouched.
                S_CLEAR: begin
                    if (ph_q == PH_FULL) begin
                        ph_q        <= '0;
                        disp_clrn_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sclk_o      = sclk_q;
    assign sdout_o     = sdout_q;
    assign disp_clrn_o = disp_clrn_q;
    assign led_pen_o   = led_pen_q;
    assign seg_pen_o   = seg_pen_q;
    assign ack_led_o   = ack_led_q;
    assign ack_seg_o   = ack_seg_q;
    assign done_led_o  = done_led_q;
    assign done_seg_o  = done_seg_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_disp_sched.sv
// Scoreboard bench for serial_disp_sched: stimulus pushes expected handshake
// events (kind + cycle) and serial bits; a negedge monitor pops and compares.
// A second instance built with CLK_DIV=1 is checked directly.
module tb_serial_disp_sched;

    localparam int EV_ACK_LED  = 0;
    localparam int EV_ACK_SEG  = 1;
    localparam int EV_PEN_LED  = 2;
    localparam int EV_PEN_SEG  = 3;
    localparam int EV_DONE_LED = 4;
    localparam int EV_DONE_SEG = 5;

    typedef struct packed {
        int kind;
        int cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n, clr_req, req_led, req_seg;
    logic [15:0] led_data;
    logic [63:0] seg_data;
    logic        ack_led, done_led, ack_seg, done_seg;
    logic        sclk, sdout, disp_clrn, led_pen, seg_pen, busy;

    logic        k_rst_n, k_clr_req, k_req_led, k_req_seg;
    logic [15:0] k_led_data;
    logic [63:0] k_seg_data;
    logic        k_ack_led, k_done_led, k_ack_seg, k_done_seg;
    logic        k_sclk, k_sdout, k_disp_clrn, k_led_pen, k_seg_pen, k_busy;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  exp_q[$];
    logic exp_bits[$];

    int   m_lp, m_sp;
    logic m_sclk_p, m_lpen_p, m_spen_p;

    always #5 clk = ~clk;

    serial_disp_sched #(.LED_BITS(16), .SEG_BITS(64), .CLK_DIV(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_req_i(clr_req),
        .req_led_i(req_led), .led_data_i(led_data), .ack_led_o(ack_led), .done_led_o(done_led),
        .req_seg_i(req_seg), .seg_data_i(seg_data), .ack_seg_o(ack_seg), .done_seg_o(done_seg),
        .sclk_o(sclk), .sdout_o(sdout), .disp_clrn_o(disp_clrn),
        .led_pen_o(led_pen), .seg_pen_o(seg_pen), .busy_o(busy)
    );

    serial_disp_sched #(.LED_BITS(16), .SEG_BITS(64), .CLK_DIV(1)) dut1 (
        .clk_i(clk), .rst_ni(k_rst_n), .clr_req_i(k_clr_req),
        .req_led_i(k_req_led), .led_data_i(k_led_data), .ack_led_o(k_ack_led), .done_led_o(k_done_led),
        .req_seg_i(k_req_seg), .seg_data_i(k_seg_data), .ack_seg_o(k_ack_seg), .done_seg_o(k_done_seg),
        .sclk_o(k_sclk), .sdout_o(k_sdout), .disp_clrn_o(k_disp_clrn),
        .led_pen_o(k_led_pen), .seg_pen_o(k_seg_pen), .busy_o(k_busy)
    );

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic string kname(input int k);
        case (k)
            EV_ACK_LED:  return "ack_led";
            EV_ACK_SEG:  return "ack_seg";
            EV_PEN_LED:  return "led_pen";
            EV_PEN_SEG:  return "seg_pen";
            EV_DONE_LED: return "done_led";
            default:     return "done_seg";
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chk_ev(input int k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event: got %s at cycle %0d, required no event", kname(k), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                failures++;
                $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                         kname(k), cyc, kname(e.kind), e.cyc);
            end
        end
    endtask

    task automatic chk_bit();
        logic b;
        checks++;
        if (exp_bits.size() == 0) begin
            failures++;
            $display("FAIL sdout: got sclk rise with bit %0b at cycle %0d, required no rise", sdout, cyc);
        end else begin
            b = exp_bits.pop_front();
            if (sdout !== b) begin
                failures++;
                $display("FAIL sdout: got %0b, required %0b at sclk rise, cycle %0d", sdout, b, cyc);
            end
        end
    endtask

    // Event timing with CLK_DIV=2: ack+65 latch start, ack+69 done (LED);
    // ack+257 latch start, ack+261 done (segment).
    task automatic push_led(input int c_ack, input logic [15:0] d);
        exp_q.push_back('{EV_ACK_LED, c_ack});
        exp_q.push_back('{EV_PEN_LED, c_ack + 65});
        exp_q.push_back('{EV_DONE_LED, c_ack + 69});
        for (int i = 15; i >= 0; i--) exp_bits.push_back(d[i]);
    endtask

    task automatic push_seg(input int c_ack, input logic [63:0] d);
        exp_q.push_back('{EV_ACK_SEG, c_ack});
        exp_q.push_back('{EV_PEN_SEG, c_ack + 257});
        exp_q.push_back('{EV_DONE_SEG, c_ack + 261});
        for (int i = 63; i >= 0; i--) exp_bits.push_back(d[i]);
    endtask

    task automatic wait_sig(input int which, input int budget, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            case (which)
                EV_ACK_LED:  seen = ack_led;
                EV_ACK_SEG:  seen = ack_seg;
                EV_DONE_LED: seen = done_led;
                default:     seen = done_seg;
            endcase
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL timeout %s: got no pulse, required one within %0d cycles", nm, budget);
        end
    endtask

    // Monitor: handshake/pen events, serial bits on sclk rises, pen widths.
    initial begin
        m_lp = 0; m_sp = 0;
        m_sclk_p = 1'b0; m_lpen_p = 1'b0; m_spen_p = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ack_led) chk_ev(EV_ACK_LED);
                if (ack_seg) chk_ev(EV_ACK_SEG);
                if (led_pen && !m_lpen_p) begin
                    chk_ev(EV_PEN_LED);
                    chk("led_pen_quiet_bus", {sclk, sdout}, 0);
                end
                if (seg_pen && !m_spen_p) begin
                    chk_ev(EV_PEN_SEG);
                    chk("seg_pen_quiet_bus", {sclk, sdout}, 0);
                end
                if (done_led) chk_ev(EV_DONE_LED);
                if (done_seg) chk_ev(EV_DONE_SEG);
                if (sclk && !m_sclk_p) chk_bit();
                if (led_pen) m_lp++;
                else if (m_lp > 0) begin chk("led_pen_len", m_lp, 4); m_lp = 0; end
                if (seg_pen) m_sp++;
                else if (m_sp > 0) begin chk("seg_pen_len", m_sp, 4); m_sp = 0; end
            end
            m_sclk_p = sclk;
            m_lpen_p = led_pen;
            m_spen_p = seg_pen;
        end
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog: got no end of test, required completion within 400000 time units");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int c0, ack_c, done_c, r1, r2, rises, ones, pen_n;
        logic [4:0] pat;
        logic kp;

        rst_n = 1'b0; clr_req = 1'b0; req_led = 1'b0; req_seg = 1'b0;
        led_data = '0; seg_data = '0;
        k_rst_n = 1'b0; k_clr_req = 1'b0; k_req_led = 1'b0; k_req_seg = 1'b0;
        k_led_data = '0; k_seg_data = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", sclk, 0);
        chk("rst_sdout", sdout, 0);
        chk("rst_pens", {led_pen, seg_pen}, 0);
        chk("rst_handshake", {ack_led, ack_seg, done_led, done_seg}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clrn", disp_clrn, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; k_rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("clrn_after_release", disp_clrn, 1);

        // LED transfer A55A
        @(posedge clk); #1;
        c0 = cyc; req_led = 1'b1; led_data = 16'hA55A;
        push_led(c0 + 1, 16'hA55A);
        wait_sig(EV_ACK_LED, 5, "ack_led_a55a");
        @(posedge clk); #1;
        req_led = 1'b0; led_data = 16'h0000;
        wait_sig(EV_DONE_LED, 100, "done_led_a55a");
        chk("busy_at_done", busy, 0);
        chk("bits_left_led", exp_bits.size(), 0);

        // Segment transfer
        @(posedge clk); #1;
        c0 = cyc; req_seg = 1'b1; seg_data = 64'h0123456789ABCDEF;
        push_seg(c0 + 1, 64'h0123456789ABCDEF);
        wait_sig(EV_ACK_SEG, 5, "ack_seg");
        @(posedge clk); #1;
        req_seg = 1'b0; seg_data = '1;
        wait_sig(EV_DONE_SEG, 300, "done_seg");
        chk("bits_left_seg", exp_bits.size(), 0);

        // Clear wins over a simultaneous LED request
        @(posedge clk); #1;
        c0 = cyc; clr_req = 1'b1; req_led = 1'b1; led_data = 16'h3C96;
        push_led(c0 + 6, 16'h3C96);
        @(posedge clk); #1;
        clr_req = 1'b0;
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pat = {pat[3:0], disp_clrn};
        end
        chk("clear_window", pat, 5'b00001);
        wait_sig(EV_ACK_LED, 5, "ack_led_after_clear");
        @(posedge clk); #1;
        req_led = 1'b0;
        wait_sig(EV_DONE_LED, 100, "done_led_after_clear");

        // Both requests held from reset: LED, SEG, LED, SEG
        @(posedge clk); #1;
        rst_n = 1'b0; req_led = 1'b1; req_seg = 1'b1;
        led_data = 16'hC3A5; seg_data = 64'hFEDCBA9876543210;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; c0 = cyc;
        push_led(c0 + 1, 16'hC3A5);
        push_seg(c0 + 71, 64'hFEDCBA9876543210);
        push_led(c0 + 333, 16'hC3A5);
        push_seg(c0 + 403, 64'hFEDCBA9876543210);
        wait_sig(EV_ACK_SEG, 100, "rr_ack_seg_1");
        wait_sig(EV_ACK_SEG, 400, "rr_ack_seg_2");
        @(posedge clk); #1;
        req_led = 1'b0; req_seg = 1'b0;
        wait_sig(EV_DONE_SEG, 300, "rr_done_seg_2");
        chk("rr_events_left", exp_q.size(), 0);

        // Reset during bit 40 (high phase) of a segment transfer
        @(posedge clk); #1;
        c0 = cyc; req_seg = 1'b1; seg_data = 64'hDEADBEEF8F9E2D3C;
        exp_q.push_back('{EV_ACK_SEG, c0 + 1});
        for (int i = 0; i < 40; i++) exp_bits.push_back(seg_data[63-i]);
        wait_sig(EV_ACK_SEG, 5, "ack_seg_abort");
        @(posedge clk); #1;
        req_seg = 1'b0;
        while (cyc < c0 + 164) begin
            @(posedge clk); #1;
        end
        chk("pre_abort_sclk", sclk, 1);
        chk("pre_abort_sdout", sdout, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_sclk_sdout", {sclk, sdout}, 0);
        chk("abort_pens", {led_pen, seg_pen}, 0);
        chk("abort_clrn", disp_clrn, 0);
        chk("abort_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_bits_left", exp_bits.size(), 0);
        chk("abort_events_left", exp_q.size(), 0);
        @(posedge clk); #1;
        c0 = cyc; req_led = 1'b1; led_data = 16'h8001;
        push_led(c0 + 1, 16'h8001);
        wait_sig(EV_ACK_LED, 5, "ack_led_post_abort");
        @(posedge clk); #1;
        req_led = 1'b0;
        wait_sig(EV_DONE_LED, 100, "done_led_post_abort");

        // CLK_DIV=1 instance, all-ones LED word
        @(posedge clk); #1;
        c0 = cyc; k_req_led = 1'b1; k_led_data = 16'hFFFF;
        ack_c = -1; done_c = -1; r1 = -1; r2 = -1; rises = 0; ones = 0; pen_n = 0;
        kp = 1'b0;
        for (int i = 0; i < 80 && done_c < 0; i++) begin
            @(negedge clk);
            if (k_ack_led && ack_c < 0) begin ack_c = cyc; k_req_led = 1'b0; end
            if (k_sclk && !kp) begin
                rises++;
                ones += int'(k_sdout);
                if (r1 < 0) r1 = cyc; else if (r2 < 0) r2 = cyc;
            end
            kp = k_sclk;
            if (k_led_pen) pen_n++;
            if (k_done_led) done_c = cyc;
        end
        chk("div1_ack_cycle", ack_c, c0 + 1);
        chk("div1_sclk_period", r2 - r1, 2);
        chk("div1_rises", rises, 16);
        chk("div1_sdout_ones", ones, 16);
        chk("div1_pen_len", pen_n, 2);
        chk("div1_done_cycle", done_c, c0 + 36);

        chk("events_left", exp_q.size(), 0);
        chk("bits_left", exp_bits.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
